// File: rtl/seq_pkg.sv
// ============================================================================
//  Module   : seq_pkg
//  Purpose  : Shared state encodings, trap causes and opcode constants for
//             the instruction sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_MEM    = 3'd4;
    localparam state_t ST_WB     = 3'd5;
    localparam state_t ST_TRAP   = 3'd6;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

    localparam logic [6:0] OP_INVALID = 7'd0;

endpackage

`default_nettype wire

// File: rtl/seq_timeout.sv
// ============================================================================
//  Module   : seq_timeout
//  Purpose  : 8-bit memory-handshake wait counter; o_expired flags the last
//             permitted wait cycle so the caller can trap on that edge.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_timeout #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [7:0] c_limit = 8'(MEM_TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_en) begin
            r_count <= r_count + 8'd1;
        end
    end

    // The count reaches MEM_TIMEOUT on the edge where this is high.
    assign o_expired = i_en && (r_count == c_limit);

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
//  Module   : instr_sequencer
//  Purpose  : Multi-cycle fetch/decode/execute/memory/writeback control FSM.
//             SEQ_PERF_CNT_EN adds perf_retired / perf_stall counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_sequencer
    import seq_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            trap_clr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    input  logic            i_type,
    input  logic            b_type,
    input  logic            l_type,
    input  logic            s_type,
    input  logic [6:0]      operation,
    input  logic [11:0]     imm,
    input  logic            branch_taken,
    output logic            alu_en,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            reg_we,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic [2:0]      state
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]     perf_retired,
    output logic [31:0]     perf_stall
`endif
);

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [1:0]      r_trap_cause;
    logic [1:0]      w_cause;
    logic            r_is_store;
    logic            r_retire;
    logic            w_complete;
    logic            w_wait;
    logic            w_expired;
    logic [XLEN-1:0] w_imm_off;
    logic [XLEN-1:0] w_pc_step;
    logic            w_unused;

    // ALU-class instructions need no special sequencing; the flag is informational.
    assign w_unused = i_type;

    assign w_wait = ((r_state == ST_FETCH) && !imem_ack) ||
                    ((r_state == ST_MEM)   && !dmem_ack);

    seq_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_next_state != r_state),
        .i_en      (w_wait),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next_state = r_state;
        w_cause      = CAUSE_NONE;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE:   if (run) w_next_state = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    w_next_state = ST_DECODE;
                end else if (w_expired) begin
                    w_next_state = ST_TRAP;
                    w_cause      = CAUSE_IMEM_TO;
                end
            end
            ST_DECODE: begin
                if (operation == OP_INVALID) begin
                    w_next_state = ST_TRAP;
                    w_cause      = CAUSE_ILLEGAL;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (l_type || s_type) w_next_state = ST_MEM;
                else if (b_type)      w_complete   = 1'b1;
                else                  w_next_state = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (r_is_store) w_complete   = 1'b1;
                    else            w_next_state = ST_WB;
                end else if (w_expired) begin
                    w_next_state = ST_TRAP;
                    w_cause      = CAUSE_DMEM_TO;
                end
            end
            ST_WB:     w_complete = 1'b1;
            ST_TRAP:   if (trap_clr) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
        if (w_complete) w_next_state = run ? ST_FETCH : ST_IDLE;
    end

    // Branch offset is in halfwords: sign-extend then shift left by one.
    assign w_imm_off = {{(XLEN-13){imm[11]}}, imm, 1'b0};
    assign w_pc_step = ((r_state == ST_EXEC) && branch_taken) ? w_imm_off : XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_instr      <= 32'd0;
            r_trap_cause <= CAUSE_NONE;
            r_is_store   <= 1'b0;
            r_retire     <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_retire <= w_complete;
            if ((r_state == ST_FETCH) && imem_ack) r_instr <= imem_rdata;
            if (r_state == ST_EXEC) r_is_store <= s_type;
            if (w_complete) begin
                r_pc <= r_pc + w_pc_step;
            end else if ((r_state == ST_TRAP) && trap_clr) begin
                r_pc <= RESET_PC;
            end
            if (r_state == ST_TRAP) begin
                if (trap_clr) r_trap_cause <= CAUSE_NONE;
            end else if (w_next_state == ST_TRAP) begin
                r_trap_cause <= w_cause;
            end
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_stall;

    // Neither event can occur in TRAP, so both counters freeze there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_retired <= 32'd0;
            r_perf_stall   <= 32'd0;
        end else begin
            if (w_complete) r_perf_retired <= r_perf_retired + 32'd1;
            if (w_wait)     r_perf_stall   <= r_perf_stall + 32'd1;
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_stall   = r_perf_stall;
`endif

    assign imem_req   = (r_state == ST_FETCH);
    assign imem_addr  = r_pc;
    assign instr      = r_instr;
    assign alu_en     = (r_state == ST_EXEC);
    assign dmem_req   = (r_state == ST_MEM);
    assign dmem_we    = (r_state == ST_MEM) && r_is_store;
    assign reg_we     = (r_state == ST_WB);
    assign pc         = r_pc;
    assign retire     = r_retire;
    assign trap       = (r_state == ST_TRAP);
    assign trap_cause = r_trap_cause;
    assign state      = r_state;

endmodule

`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control FSM that sequences the core datapath: fetch -> decode -> execute -> memory -> writeback.
- Owns the PC and the instruction register.
- Handshakes with instruction and data memories.
- Consumes class flags, operation code and immediate from the combinational decoder; drives the ALU, memory and register-file strobes.
- Raises a sticky trap on an illegal instruction or a memory timeout.

Parameters:
- XLEN, 32, PC and address width.
- RESET_PC, 32'h0000_0000, PC value after reset and after trap clear.
- MEM_TIMEOUT, 15, maximum wait cycles for imem_ack/dmem_ack before trapping (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- trap_clr  in  1  one-cycle pulse; leave TRAP.
- imem_req  out  1  fetch request; held until ack.
- imem_addr  out  XLEN  fetch address (= pc).
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  instruction register, fed to the decoder.
- i_type, b_type, l_type, s_type  in  1 each  decoder class flags.
- operation  in  7  decoder operation code; 0 = invalid.
- imm  in  12  decoder immediate.
- branch_taken  in  1  ALU compare result, sampled in EXEC.
- alu_en  out  1  ALU evaluate strobe.
- dmem_req  out  1  data access request; held until ack.
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
- dmem_ack  in  1  data access complete.
- reg_we  out  1  register-file write strobe.
- pc  out  XLEN  current program counter.
- retire  out  1  one-cycle pulse per completed instruction.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  0 none, 1 illegal, 2 imem timeout, 3 dmem timeout.
- state  out  3  FSM state, for debug.

Behaviour:
- Reset values: state = IDLE; pc = RESET_PC; instr = 0; trap = 0; trap_cause = 0; timeout count = 0. All strobes (imem_req, dmem_req, dmem_we, alu_en, reg_we, retire) are 0.
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 6. All outputs are registered or decoded from state only, so there is no combinational path from an input to an output.
- IDLE: when run = 1 -> FETCH.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - On imem_ack: instr <= imem_rdata, go to DECODE.
  - The timeout counter increments on each cycle without ack. When it reaches MEM_TIMEOUT: go to TRAP with cause 2.
- DECODE: one cycle, letting the decoder settle on instr. If operation == 0 -> TRAP with cause 1; otherwise -> EXEC.
- EXEC: alu_en = 1 for exactly one cycle. Next state:
  - l_type or s_type -> MEM.
  - b_type -> completes here. pc <= pc + (branch_taken ? sext(imm) << 1 : 4); retire = 1.
  - otherwise -> WB.
- MEM:
  - dmem_req = 1, dmem_we = s_type.
  - On dmem_ack: a load goes to WB. A store completes here: pc <= pc + 4, retire = 1.
  - Timeout as in FETCH -> TRAP with cause 3.
- WB: reg_we = 1 for one cycle; pc <= pc + 4; retire = 1.
- After completion (branch, store or WB): go to FETCH if run = 1, else IDLE.
- PC arithmetic is modulo 2^XLEN, with silent wrap-around. The timeout counter clears on every state change.
- Dropping run mid-instruction does not abort: the instruction completes and retires, then the FSM goes to IDLE.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- Zero-wait memories: an ALU instruction takes 4 cycles (FETCH, DECODE, EXEC, WB); a load takes 5.
- TRAP:
  - trap = 1; trap_cause and pc are held; all strobes are 0.
  - trap_clr -> IDLE with pc <= RESET_PC, trap = 0, trap_cause = 0.
  - trap_clr in any other state is ignored.
- Asserting rst_n low in any state, including mid-handshake, immediately forces all reset values; outstanding requests are dropped.

Optional Feature:
SEQ_PERF_CNT_EN
- Defined: adds two 32-bit output ports.
  - perf_retired counts retire pulses.
  - perf_stall counts FETCH/MEM cycles spent waiting for ack.
  - Both reset to 0, wrap at 2^32, and are frozen in TRAP.
- Undefined: neither the ports nor the counter logic exist.

Decomposition:
- Package seq_pkg holds:
  - the state typedef with the encodings above;
  - trap cause constants CAUSE_NONE/ILLEGAL/IMEM_TO/DMEM_TO;
  - OP_INVALID = 7'd0.
- One sub-module, seq_timeout: an 8-bit wait counter with clear, enable and an expired flag compared against MEM_TIMEOUT. It is instantiated once and shared by FETCH and MEM.

Test Plan:
- run = 1, zero-wait imem returns ADDI (operation = 1, i_type) -> alu_en in cycle 3, reg_we in cycle 4, pc 0 -> 4, one retire pulse.
- BEQ with imm = 12'h004 and branch_taken = 1 at pc = 8 -> pc = 16, no reg_we, retire in EXEC; repeat with branch_taken = 0 -> pc = 12.
- LW with dmem_ack delayed 3 cycles -> dmem_req held for 4 cycles with dmem_we = 0, then reg_we, pc += 4. SW -> dmem_we = 1, no reg_we.
- operation = 0 after fetch -> trap = 1, trap_cause = 1, pc held. trap_clr -> IDLE, pc = RESET_PC.
- imem_ack never asserted -> trap with cause 2 after exactly 15 cycles in FETCH. Also: rst_n low during MEM -> dmem_req drops immediately, state = IDLE.
- With SEQ_PERF_CNT_EN: 3 ALU instructions plus one load with 2 wait cycles -> perf_retired = 4, perf_stall = 2.
